// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types and sizes for the scalar register file write-back path.
//   SGPR_* / SMEM_*  : default geometry of the register file and load returns
//   sgpr_wb_req_t    : one buffered scalar-memory load return
//   sgpr_wb_state_t  : drain FSM encoding
//   beat_is_wide()   : decides whether a load beat can use the 64-bit port
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int SGPR_BANKS         = 16;   // MAX_WAVEFRONT_CNT
    localparam int SGPR_DEPTH         = 128;
    localparam int SGPR_DATA_WIDTH    = 32;
    localparam int SGPR_WB_FIFO_DEPTH = 4;
    localparam int SMEM_MAX_DWORDS    = 16;

    localparam int SGPR_BANK_W   = $clog2(SGPR_BANKS);
    localparam int SGPR_ADDR_W   = $clog2(SGPR_DEPTH);
    localparam int SMEM_DWORDS_W = 5;

    typedef struct packed {
        logic [SGPR_BANK_W-1:0]                     bank;
        logic [SGPR_ADDR_W-1:0]                     addr;
        logic [SMEM_DWORDS_W-1:0]                   dwords;
        logic [SMEM_MAX_DWORDS*SGPR_DATA_WIDTH-1:0] data;
    } sgpr_wb_req_t;

    typedef enum logic {
        WB_IDLE  = 1'b0,
        WB_DRAIN = 1'b1
    } sgpr_wb_state_t;

    // A 64-bit write is only legal at an even register with two dwords left.
    function automatic logic beat_is_wide(input logic addr_lsb,
                                          input logic [SMEM_DWORDS_W-1:0] rem);
        return !addr_lsb && (rem >= SMEM_DWORDS_W'(2));
    endfunction

endpackage

// File: rtl/sgpr_wb_fifo.sv
// -----------------------------------------------------------------------------
// sgpr_wb_fifo
// Synchronous FIFO of whole scalar-memory load returns.
//   clk, rst_n   : clock, asynchronous active-low reset (empties the FIFO)
//   i_push/i_data: write one entry (ignored when full)
//   i_pop        : retire the head entry (ignored when empty)
//   o_head       : current head entry (meaningless when empty)
//   o_full/o_empty/o_count : occupancy
// -----------------------------------------------------------------------------
module sgpr_wb_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = SGPR_WB_FIFO_DEPTH
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  sgpr_wb_req_t               i_data,
    input  logic                       i_pop,
    output sgpr_wb_req_t               o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    sgpr_wb_req_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sgpr_wb_arb.sv
// -----------------------------------------------------------------------------
// sgpr_wb_arb
// Write-back arbiter in front of the scalar register file's single write port.
// SALU results pass straight through with absolute priority; scalar-memory load
// returns are buffered and split into aligned 32/64-bit register writes.
//   clk, reset_n                       : clock, asynchronous active-low reset
//   salu_valid/bank/addr/data/strb     : SALU write request (no backpressure)
//   smem_valid/ready/bank/addr/dwords/data : load return handshake
//   wr_bank_sel/waddr/wdata/wstrb/wenable  : register file write port (registered)
//   smem_done/smem_done_bank           : pulse on the last beat of a load
//   err                                : sticky (zero-length load or address overflow)
//   busy                               : loads buffered or being drained
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// WB_IDLE  | FIFO empty, nothing to drain
// WB_DRAIN | head entry being split into beats; r_idx = dwords already issued
// -----------------------------------------------------------------------------
module sgpr_wb_arb
    import mem_pkg::*;
#(
    parameter int BANKS      = SGPR_BANKS,
    parameter int DEPTH      = SGPR_DEPTH,
    parameter int DATA_WIDTH = SGPR_DATA_WIDTH,
    parameter int FIFO_DEPTH = SGPR_WB_FIFO_DEPTH,
    parameter int MAX_DWORDS = SMEM_MAX_DWORDS
)(
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             salu_valid,
    input  logic [$clog2(BANKS)-1:0]         salu_bank,
    input  logic [$clog2(DEPTH)-1:0]         salu_addr,
    input  logic [2*DATA_WIDTH-1:0]          salu_data,
    input  logic [1:0]                       salu_strb,
    input  logic                             smem_valid,
    output logic                             smem_ready,
    input  logic [$clog2(BANKS)-1:0]         smem_bank,
    input  logic [$clog2(DEPTH)-1:0]         smem_addr,
    input  logic [4:0]                       smem_dwords,
    input  logic [MAX_DWORDS*DATA_WIDTH-1:0] smem_data,
    output logic [$clog2(BANKS)-1:0]         wr_bank_sel,
    output logic [$clog2(DEPTH)-1:0]         waddr,
    output logic [2*DATA_WIDTH-1:0]          wdata,
    output logic [1:0]                       wstrb,
    output logic                             wenable,
    output logic                             smem_done,
    output logic [$clog2(BANKS)-1:0]         smem_done_bank,
    output logic                             err,
    output logic                             busy
);

    localparam int BANK_W = $clog2(BANKS);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int IDX_W  = $clog2(MAX_DWORDS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH+1);

    sgpr_wb_state_t r_state, w_state_nxt;
    logic [4:0]     r_idx, w_idx_nxt;

    logic [BANK_W-1:0]       r_wr_bank_sel, w_bank_nxt;
    logic [ADDR_W-1:0]       r_waddr, w_addr_nxt;
    logic [2*DATA_WIDTH-1:0] r_wdata, w_data_nxt;
    logic [1:0]              r_wstrb, w_strb_nxt;
    logic                    r_wenable, w_we_nxt;
    logic                    r_smem_done, w_done_nxt;
    logic [BANK_W-1:0]       r_smem_done_bank, w_done_bank_nxt;
    logic                    r_err;
    logic                    r_busy;
    logic                    r_smem_ready;

    sgpr_wb_req_t     w_req;
    sgpr_wb_req_t     w_head;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_legal;
    logic             w_push;
    logic             w_bad;
    logic             w_pop;
    logic             w_beat;

    logic [ADDR_W:0]         w_cur_addr;
    logic [4:0]              w_rem;
    logic                    w_ovf;
    logic                    w_wide;
    logic [4:0]              w_adv;
    logic                    w_last;
    logic [IDX_W-1:0]        w_idx_lo;
    logic [IDX_W-1:0]        w_idx_hi;
    logic [DATA_WIDTH-1:0]   w_lo;
    logic [DATA_WIDTH-1:0]   w_hi;

    assign w_req = '{bank: smem_bank, addr: smem_addr, dwords: smem_dwords, data: smem_data};

    // Zero-length (or oversize) returns complete the handshake but never enter the FIFO.
    assign w_legal   = (smem_dwords != 5'd0) && (smem_dwords <= 5'(MAX_DWORDS));
    assign w_push    = smem_valid && r_smem_ready && !w_full && w_legal;
    assign w_bad     = smem_valid && r_smem_ready && !w_legal;
    assign w_cnt_nxt = w_count + CNT_W'(w_push) - CNT_W'(w_pop);

    sgpr_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_push  (w_push),
        .i_data  (w_req),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Beat geometry is derived from the head entry plus dwords already issued,
    // so the next entry can start the cycle after a pop without reloading state.
    always_comb begin
        w_cur_addr = {1'b0, w_head.addr} + (ADDR_W+1)'(r_idx);
        w_rem      = w_head.dwords - r_idx;
        w_ovf      = (w_cur_addr > (ADDR_W+1)'(DEPTH-1));
        w_wide     = beat_is_wide(w_cur_addr[0], w_rem);
        w_adv      = w_wide ? 5'd2 : 5'd1;
        w_last     = w_ovf || (w_rem == w_adv);
        w_idx_lo   = r_idx[IDX_W-1:0];
        w_idx_hi   = w_idx_lo + IDX_W'(1);
        w_lo       = w_head.data[w_idx_lo*DATA_WIDTH +: DATA_WIDTH];
        w_hi       = w_head.data[w_idx_hi*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_pop       = 1'b0;
        w_beat      = 1'b0;
        case (r_state)
            WB_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = WB_DRAIN;
                    w_idx_nxt   = '0;
                end
            end
            WB_DRAIN: begin
                if (!salu_valid) begin
                    w_beat = 1'b1;
                    if (w_last) begin
                        w_pop     = 1'b1;
                        w_idx_nxt = '0;
                        if ((w_count <= CNT_W'(1)) && !w_push) begin
                            w_state_nxt = WB_IDLE;
                        end
                    end else begin
                        w_idx_nxt = r_idx + w_adv;
                    end
                end
            end
            default: begin
                w_state_nxt = WB_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_we_nxt        = 1'b0;
        w_bank_nxt      = r_wr_bank_sel;
        w_addr_nxt      = r_waddr;
        w_data_nxt      = r_wdata;
        w_strb_nxt      = r_wstrb;
        w_done_nxt      = w_beat && w_last;
        w_done_bank_nxt = r_smem_done_bank;
        if (salu_valid) begin
            w_we_nxt   = 1'b1;
            w_bank_nxt = salu_bank;
            w_addr_nxt = salu_addr;
            w_data_nxt = salu_data;
            w_strb_nxt = salu_strb;
        end else if (w_beat && !w_ovf) begin
            w_we_nxt   = 1'b1;
            w_bank_nxt = w_head.bank;
            w_addr_nxt = w_cur_addr[ADDR_W-1:0];
            w_data_nxt = w_wide ? {w_hi, w_lo} : {{DATA_WIDTH{1'b0}}, w_lo};
            w_strb_nxt = w_wide ? 2'b11 : 2'b01;
        end
        if (w_done_nxt) begin
            w_done_bank_nxt = w_head.bank;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= WB_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_bank_sel    <= '0;
            r_waddr          <= '0;
            r_wdata          <= '0;
            r_wstrb          <= '0;
            r_wenable        <= 1'b0;
            r_smem_done      <= 1'b0;
            r_smem_done_bank <= '0;
            r_err            <= 1'b0;
            r_busy           <= 1'b0;
            r_smem_ready     <= 1'b0;
        end else begin
            r_wr_bank_sel    <= w_bank_nxt;
            r_waddr          <= w_addr_nxt;
            r_wdata          <= w_data_nxt;
            r_wstrb          <= w_strb_nxt;
            r_wenable        <= w_we_nxt;
            r_smem_done      <= w_done_nxt;
            r_smem_done_bank <= w_done_bank_nxt;
            r_err            <= r_err | w_bad | (w_beat && w_ovf);
            // The in-flight load stays at the FIFO head until its last beat,
            // so a non-empty FIFO covers the drain as well.
            r_busy           <= (w_cnt_nxt != '0);
            r_smem_ready     <= (w_cnt_nxt != CNT_W'(FIFO_DEPTH));
        end
    end

    assign wr_bank_sel    = r_wr_bank_sel;
    assign waddr          = r_waddr;
    assign wdata          = r_wdata;
    assign wstrb          = r_wstrb;
    assign wenable        = r_wenable;
    assign smem_done      = r_smem_done;
    assign smem_done_bank = r_smem_done_bank;
    assign err            = r_err;
    assign busy           = r_busy;
    assign smem_ready     = r_smem_ready;

endmodule

// File: tb/tb_sgpr_wb_arb.sv
// -----------------------------------------------------------------------------
// tb_sgpr_wb_arb
// Scoreboard bench for sgpr_wb_arb. Each accepted load return is expanded into
// its list of register writes when it is issued; SALU writes are expected in
// the cycle after they are driven. A negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_sgpr_wb_arb;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         salu_valid;
    logic [3:0]   salu_bank;
    logic [6:0]   salu_addr;
    logic [63:0]  salu_data;
    logic [1:0]   salu_strb;
    logic         smem_valid;
    logic         smem_ready;
    logic [3:0]   smem_bank;
    logic [6:0]   smem_addr;
    logic [4:0]   smem_dwords;
    logic [511:0] smem_data;
    logic [3:0]   wr_bank_sel;
    logic [6:0]   waddr;
    logic [63:0]  wdata;
    logic [1:0]   wstrb;
    logic         wenable;
    logic         smem_done;
    logic [3:0]   smem_done_bank;
    logic         err;
    logic         busy;

    always #5 clk = ~clk;

    sgpr_wb_arb dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .salu_valid     (salu_valid),
        .salu_bank      (salu_bank),
        .salu_addr      (salu_addr),
        .salu_data      (salu_data),
        .salu_strb      (salu_strb),
        .smem_valid     (smem_valid),
        .smem_ready     (smem_ready),
        .smem_bank      (smem_bank),
        .smem_addr      (smem_addr),
        .smem_dwords    (smem_dwords),
        .smem_data      (smem_data),
        .wr_bank_sel    (wr_bank_sel),
        .waddr          (waddr),
        .wdata          (wdata),
        .wstrb          (wstrb),
        .wenable        (wenable),
        .smem_done      (smem_done),
        .smem_done_bank (smem_done_bank),
        .err            (err),
        .busy           (busy)
    );

    typedef struct {
        int          cyc;
        logic [3:0]  bank;
        logic [6:0]  addr;
        logic [63:0] data;
        logic [1:0]  strb;
    } salu_exp_t;

    typedef struct {
        logic [3:0]  bank;
        int          addr;
        logic [63:0] data;
        logic [1:0]  strb;
        bit          last;
        bit          supp;
    } beat_t;

    salu_exp_t sq[$];
    beat_t     bq[$];
    int        beat_cyc[$];
    int        checks = 0;
    int        errors = 0;
    int        cyc = 0;
    int        n_we = 0;
    bit        model_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string msg);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s", msg);
        end
    endtask

    // Reference: walk the load dword by dword using the register file's alignment rules.
    function automatic void model_push(input logic [3:0] bank, input logic [6:0] addr,
                                       input logic [4:0] dwords, input logic [511:0] data);
        int a;
        int i;
        int n;
        beat_t b;
        if (dwords == 0) begin
            model_err = 1;
            return;
        end
        a = addr;
        i = 0;
        n = dwords;
        while (i < n) begin
            b.bank = bank;
            b.addr = a;
            b.supp = 0;
            if (a > 127) begin
                b.supp = 1;
                b.last = 1;
                b.data = '0;
                b.strb = '0;
                model_err = 1;
                bq.push_back(b);
                break;
            end
            if ((a % 2) == 1 || (n - i) == 1) begin
                b.data = {32'b0, data[32*i +: 32]};
                b.strb = 2'b01;
                i += 1;
                a += 1;
            end else begin
                b.data = {data[32*(i+1) +: 32], data[32*i +: 32]};
                b.strb = 2'b11;
                i += 2;
                a += 2;
            end
            b.last = (i == n);
            bq.push_back(b);
        end
    endfunction

    // Called at posedge+1: records what the currently driven inputs will cause, then advances.
    task automatic drive_cycle();
        salu_exp_t s;
        if (salu_valid) begin
            s.cyc  = cyc + 1;
            s.bank = salu_bank;
            s.addr = salu_addr;
            s.data = salu_data;
            s.strb = salu_strb;
            sq.push_back(s);
        end
        if (smem_valid && smem_ready) begin
            model_push(smem_bank, smem_addr, smem_dwords, smem_data);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] rand_data();
        logic [511:0] d;
        for (int j = 0; j < 16; j++) d[32*j +: 32] = $urandom();
        return d;
    endfunction

    task automatic salu_rand();
        salu_valid = 1'b1;
        salu_bank  = 4'($urandom_range(0, 15));
        salu_addr  = 7'($urandom_range(0, 127));
        salu_data  = {$urandom(), $urandom()};
        salu_strb  = 2'($urandom_range(1, 3));
    endtask

    task automatic send_load(input logic [3:0] b, input logic [6:0] a,
                             input logic [4:0] n, input logic [511:0] d);
        smem_valid  = 1'b1;
        smem_bank   = b;
        smem_addr   = a;
        smem_dwords = n;
        smem_data   = d;
        chk(smem_ready == 1'b1, $sformatf("load_ready got %0d want 1", smem_ready));
        drive_cycle();
        smem_valid = 1'b0;
    endtask

    task automatic wait_drained(input string tag);
        int k;
        k = 0;
        salu_valid = 1'b0;
        smem_valid = 1'b0;
        while ((bq.size() != 0 || sq.size() != 0) && k < 400) begin
            drive_cycle();
            k++;
        end
        chk(k < 400, $sformatf("%s_drain_timeout got %0d pending want 0", tag, bq.size() + sq.size()));
        bq.delete();
        sq.delete();
        drive_cycle();
        drive_cycle();
        chk(busy == 1'b0 && smem_ready == 1'b1,
            $sformatf("%s_idle got busy=%0d ready=%0d want busy=0 ready=1", tag, busy, smem_ready));
    endtask

    always @(negedge clk) begin
        salu_exp_t s;
        beat_t     b;
        bit        ok;
        if (reset_n) begin
            if (sq.size() > 0 && sq[0].cyc == cyc) begin
                s = sq.pop_front();
                chk(wenable && wr_bank_sel == s.bank && waddr == s.addr && wdata == s.data &&
                    wstrb == s.strb && !smem_done,
                    $sformatf("salu_write got we=%0d bank=%0d addr=%0d data=%h strb=%b done=%0d want we=1 bank=%0d addr=%0d data=%h strb=%b done=0",
                              wenable, wr_bank_sel, waddr, wdata, wstrb, smem_done,
                              s.bank, s.addr, s.data, s.strb));
                n_we += int'(wenable);
            end else if (wenable || smem_done) begin
                if (bq.size() == 0) begin
                    chk(1'b0, $sformatf("unexpected_write got we=%0d addr=%0d done=%0d want no activity",
                                        wenable, waddr, smem_done));
                end else begin
                    b  = bq.pop_front();
                    ok = (wenable == !b.supp) && (smem_done == b.last) &&
                         (!b.last || smem_done_bank == b.bank) &&
                         (b.supp || (wr_bank_sel == b.bank && waddr == b.addr[6:0] &&
                                     wdata == b.data && wstrb == b.strb)) &&
                         (!b.supp || err);
                    chk(ok, $sformatf("smem_beat got we=%0d bank=%0d addr=%0d data=%h strb=%b done=%0d dbank=%0d err=%0d want we=%0d bank=%0d addr=%0d data=%h strb=%b done=%0d",
                                      wenable, wr_bank_sel, waddr, wdata, wstrb, smem_done,
                                      smem_done_bank, err, !b.supp, b.bank, b.addr, b.data,
                                      b.strb, b.last));
                    if (!b.supp) beat_cyc.push_back(cyc);
                end
                n_we += int'(wenable);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [511:0] d;
        int g;
        int we0;
        reset_n     = 1'b0;
        salu_valid  = 1'b0;
        salu_bank   = '0;
        salu_addr   = '0;
        salu_data   = '0;
        salu_strb   = '0;
        smem_valid  = 1'b0;
        smem_bank   = '0;
        smem_addr   = '0;
        smem_dwords = '0;
        smem_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk(!wenable && !smem_done && !err && !busy && !smem_ready && waddr == 0 && wdata == 0 &&
            wstrb == 0 && wr_bank_sel == 0 && smem_done_bank == 0,
            $sformatf("reset_outputs got we=%0d done=%0d err=%0d busy=%0d ready=%0d want all 0",
                      wenable, smem_done, err, busy, smem_ready));
        reset_n = 1'b1;
        drive_cycle();
        chk(smem_ready == 1'b1, $sformatf("ready_after_reset got %0d want 1", smem_ready));

        // SALU pass-through
        salu_valid = 1'b1;
        salu_bank  = 4'd3;
        salu_addr  = 7'd10;
        salu_data  = 64'hAAAA_BBBB_CCCC_DDDD;
        salu_strb  = 2'b11;
        drive_cycle();
        wait_drained("salu");

        // Aligned 4-dword load: two back-to-back 64-bit beats
        beat_cyc.delete();
        send_load(4'd2, 7'd20, 5'd4, rand_data());
        wait_drained("aligned");
        chk(beat_cyc.size() == 2 && beat_cyc[1] == beat_cyc[0] + 1,
            $sformatf("aligned_back_to_back got %0d beats want 2 consecutive", beat_cyc.size()));

        // Odd start: 32-bit, 64-bit, 32-bit
        beat_cyc.delete();
        send_load(4'd5, 7'd7, 5'd4, rand_data());
        wait_drained("odd");
        chk(beat_cyc.size() == 3 && beat_cyc[2] == beat_cyc[0] + 2,
            $sformatf("odd_three_beats got %0d beats want 3 consecutive", beat_cyc.size()));

        // Collision: two SALU writes in the middle of a 4-dword drain
        we0 = n_we;
        send_load(4'd9, 7'd40, 5'd4, rand_data());
        drive_cycle();
        drive_cycle();
        salu_rand();
        drive_cycle();
        salu_rand();
        drive_cycle();
        salu_valid = 1'b0;
        wait_drained("collision");
        chk(n_we - we0 == 4, $sformatf("collision_write_count got %0d want 4", n_we - we0));

        // Backpressure: SALU hogs the port while four loads fill the FIFO
        for (int k = 0; k < 4; k++) begin
            salu_rand();
            if (k == 0) send_load(4'd1, 7'd50, 5'd1, rand_data());
            else        send_load(4'($urandom_range(0, 15)), 7'($urandom_range(0, 100)),
                                  5'($urandom_range(2, 16)), rand_data());
        end
        chk(smem_ready == 1'b0 && busy == 1'b1,
            $sformatf("fifo_full got ready=%0d busy=%0d want ready=0 busy=1", smem_ready, busy));
        smem_valid  = 1'b1;
        smem_bank   = 4'd12;
        smem_addr   = 7'd64;
        smem_dwords = 5'd3;
        smem_data   = rand_data();
        for (int k = 0; k < 5; k++) begin
            salu_rand();
            drive_cycle();
        end
        chk(smem_ready == 1'b0, $sformatf("fifth_held got ready=%0d want 0", smem_ready));
        salu_valid = 1'b0;
        g = 0;
        while (!smem_ready && g < 20) begin
            drive_cycle();
            g++;
        end
        chk(g == 1, $sformatf("ready_after_one_pop got %0d cycles want 1", g));
        drive_cycle();
        smem_valid = 1'b0;
        wait_drained("backpressure");

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 9) < 3) salu_rand();
            else salu_valid = 1'b0;
            smem_valid  = ($urandom_range(0, 9) < 3);
            smem_bank   = 4'($urandom_range(0, 15));
            smem_addr   = 7'($urandom_range(0, 127));
            smem_dwords = ($urandom_range(0, 19) == 0) ? 5'd0 : 5'($urandom_range(1, 16));
            smem_data   = rand_data();
            drive_cycle();
        end
        wait_drained("random");
        chk(err == model_err, $sformatf("err_random got %0d want %0d", err, model_err));

        // Overflow at the top of the bank, then reset during a new drain
        send_load(4'd7, 7'd126, 5'd4, rand_data());
        wait_drained("overflow");
        chk(err == 1'b1, $sformatf("err_overflow got %0d want 1", err));
        send_load(4'd6, 7'd0, 5'd16, rand_data());
        drive_cycle();
        drive_cycle();
        drive_cycle();
        #2;
        reset_n = 1'b0;
        #1;
        chk(!wenable && !smem_done && !err && !busy && !smem_ready && waddr == 0 && wdata == 0 &&
            wstrb == 0 && wr_bank_sel == 0 && smem_done_bank == 0,
            $sformatf("async_reset got we=%0d done=%0d err=%0d busy=%0d ready=%0d want all 0",
                      wenable, smem_done, err, busy, smem_ready));
        sq.delete();
        bq.delete();
        model_err = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive_cycle();
        chk(smem_ready == 1'b1 && busy == 1'b0,
            $sformatf("after_reset got ready=%0d busy=%0d want ready=1 busy=0", smem_ready, busy));
        repeat (20) drive_cycle();
        chk(err == 1'b0 && busy == 1'b0,
            $sformatf("no_stale_drain got err=%0d busy=%0d want 0 0", err, busy));
        chk(bq.size() == 0 && sq.size() == 0,
            $sformatf("scoreboard_empty got %0d pending want 0", bq.size() + sq.size()));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sgpr_wb_arb.md
Name: sgpr_wb_arb

Overview:
- Write-back arbiter sitting directly upstream of the scalar register file's single write port (wr_bank_sel/waddr/wdata/wstrb/wenable).
- Merges two sources:
  - SALU results: one 64-bit write per cycle, no backpressure.
  - Scalar-memory load returns: 1..16 dwords, buffered in a FIFO.
- Splits load returns into aligned 32/64-bit register writes that obey the register file's odd/even address rules.
- Signals load completion per wavefront so the scoreboard can release the destination registers.

Parameters:
- BANKS, MAX_WAVEFRONT_CNT (16): number of wavefront banks.
- DEPTH, SGPR_DEPTH (128): registers per bank.
- DATA_WIDTH, SGPR_DATA_WIDTH (32): register width.
- FIFO_DEPTH, SGPR_WB_FIFO_DEPTH (4): number of buffered whole load returns.
- MAX_DWORDS, SMEM_MAX_DWORDS (16): maximum dwords per load return.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset
- salu_valid  in  1  SALU write request
- salu_bank  in  $clog2(BANKS)  wavefront bank
- salu_addr  in  $clog2(DEPTH)  destination register (odd means 32-bit write)
- salu_data  in  2*DATA_WIDTH  write data
- salu_strb  in  2  dword strobes
- smem_valid  in  1  load return valid
- smem_ready  out  1  FIFO can accept a return
- smem_bank  in  $clog2(BANKS)  wavefront bank
- smem_addr  in  $clog2(DEPTH)  first destination register
- smem_dwords  in  5  dword count (1..16)
- smem_data  in  MAX_DWORDS*DATA_WIDTH  load data; dword i is in bits [32i+31:32i]
- wr_bank_sel  out  $clog2(BANKS)  to register file
- waddr  out  $clog2(DEPTH)  to register file
- wdata  out  2*DATA_WIDTH  to register file
- wstrb  out  2  to register file
- wenable  out  1  to register file
- smem_done  out  1  one-cycle pulse on the last beat of a load
- smem_done_bank  out  $clog2(BANKS)  bank of the completed load
- err  out  1  sticky error flag
- busy  out  1  FIFO non-empty or drain in progress

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low.
  - All outputs reset to 0 and the FIFO is emptied.
  - The drain FSM returns to IDLE.
  - Reset mid-drain discards the in-flight load; no done pulse is issued for it.
- Registered outputs, one-cycle latency: a request selected in cycle t appears on wenable/waddr/wdata/wstrb in cycle t+1.
- SALU path:
  - Absolute priority; forwarded unchanged.
  - wenable=salu_valid.
  - No alignment checking; the register file handles odd addresses.
- smem_ready is ~full, based on the registered count.
  - A push is accepted when smem_valid && smem_ready.
  - A push and a pop in the same cycle leave the count unchanged.
- smem_dwords=0 is illegal: the return is dropped, err is set, smem_ready is unaffected.
- Drain FSM states: IDLE and DRAIN.
  - IDLE to DRAIN when the FIFO is non-empty. Load the head entry into cur_addr, rem=dwords, idx=0.
  - DRAIN issues one beat per cycle in which salu_valid=0. When salu_valid=1 the beat stalls and state is held.
- Beat formation rules:
  - cur_addr odd: 32-bit beat. waddr=cur_addr, wdata={32'b0, dword[idx]}, wstrb=01. Advance by 1.
  - cur_addr even and rem>=2: 64-bit beat. wdata={dword[idx+1], dword[idx]}, wstrb=11. Advance by 2.
  - cur_addr even and rem==1: wdata={32'b0, dword[idx]}, wstrb=01. Advance by 1.
- Last beat (rem reaches 0):
  - smem_done=1 with smem_done_bank, aligned with that beat's wenable.
  - Pop the FIFO.
  - If the FIFO is still non-empty, go directly to the next entry with no bubble; otherwise go to IDLE.
- Address overflow: a beat whose address would exceed DEPTH-1 is suppressed.
  - The remaining dwords are discarded, err is set, and done still pulses on the final (suppressed) beat cycle.
- No SALU/SMEM register hazard checking; ordering is guaranteed by s_waitcnt.
- Sustained salu_valid can starve the drain indefinitely. This is allowed; busy stays high.

Decomposition:
- mem_pkg:
  - SGPR_WB_FIFO_DEPTH and SMEM_MAX_DWORDS.
  - typedef sgpr_wb_req_t, a packed struct {bank, addr, dwords, data}.
- One sub-module, sgpr_wb_fifo: a generic synchronous FIFO of sgpr_wb_req_t with full, empty, push and pop.
- The FSM and beat formation stay in sgpr_wb_arb.

Test Plan:
- SALU: salu_valid, bank 3, addr 10, data 64'hAAAA_BBBB_CCCC_DDDD, strb 11 -> next cycle wenable=1, wr_bank_sel=3, waddr=10, same data and strb.
- SMEM aligned: bank 2, addr 20, 4 dwords D0..D3 -> beats (20, 11, {D1,D0}) then (22, 11, {D3,D2}) on consecutive cycles; smem_done=1 with bank 2 on the second beat.
- SMEM odd start: addr 7, 4 dwords -> beats (7, 01, D0), (8, 11, {D2,D1}), (10, 01, D3); done on the third beat.
- Collision: salu_valid asserted for 2 cycles during a 4-dword drain -> the two SALU writes appear first, SMEM beats resume afterwards in order with no beat lost or duplicated; total 4 write cycles (2 SALU + 2 SMEM).
- Backpressure: hold salu_valid=1 and push 4 returns -> smem_ready=0 and a fifth return is held until salu_valid drops and one pop occurs.
- Overflow and reset: addr 126, 4 dwords -> (126, 11) written, the rest suppressed, err=1, done pulses. Then assert reset_n=0 mid-drain of a new load -> all outputs 0 asynchronously, FIFO empty, err cleared.
